acc_alu_sequencer: RTL

Program sequencer for the 8-bit accumulator ALU. A host loads up to 16 instruction bytes into a local program store, pulses `start`, and the block fetches and executes them against an internal 8-bit accumulator until HALT, then reports completion. The instruction byte format is the ALU's: opcode in [3:0], 4-bit operand in [7:4]. Adding control flow (load-immediate, conditional jump) and a runaway guard lets the datapath run small programs without host stepping.

---
 rtl/acc_alu_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/acc_alu_sequencer.sv
// acc_alu_sequencer: runs small programs from a 16-byte local store against an
// 8-bit accumulator. Host loads bytes and pulses start while IDLE; the block
// alternates FETCH/EXEC until HALT or the step limit, then pulses done.
// Handshake: prog_we and start are single-cycle strobes accepted only in IDLE;
// done is a one-cycle completion pulse; busy covers FETCH and EXEC.
module acc_alu_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int MAX_STEPS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        acc,
    output logic [ADDR_W-1:0] pc
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_LDI  = 4'b0110;
    localparam logic [3:0] OP_JNZ  = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          acc_q, acc_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [7:0]          mem [DEPTH];
    logic                mem_we;
    logic [7:0]          imm;
    logic [3:0]          op;

    assign mem_we = (state_q == S_IDLE) && prog_we;
    assign imm    = {4'b0000, ir_q[7:4]};
    assign op     = ir_q[3:0];

    // Program store: no reset so contents survive rst; writes only while IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Next-state and datapath decode for the sequencer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        step_d  = step_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = 8'h00;
                    pc_d    = '0;
                    step_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = mem[pc_q];
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                step_d = step_q + STEP_W'(1);
                case (op)
                    OP_NOP: ;
                    OP_ADD: acc_d = acc_q + imm;
                    OP_SUB: acc_d = acc_q - imm;
                    OP_AND: acc_d = acc_q & imm;
                    OP_OR:  acc_d = acc_q | imm;
                    OP_NOT: acc_d = ~acc_q;
                    OP_LDI: acc_d = imm;
                    OP_JNZ: begin
                        if (acc_q != 8'h00) begin
                            pc_d = ADDR_W'(ir_q[7:4]);
                        end
                    end
                    default: ;
                endcase
                if (op == OP_HALT) begin
                    state_d = S_DONE;
                end else if (step_q == STEP_W'(MAX_STEPS - 1)) begin
                    // Runaway guard: this was the last allowed step.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_FETCH) || (state_d == S_EXEC);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs; rst aborts any run immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 8'h00;
            pc_q    <= '0;
            ir_q    <= 8'h00;
            step_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            step_q  <= step_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign acc  = acc_q;
    assign pc   = pc_q;

endmodule
